// File: rtl/t2mi_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : t2mi_stream_arbiter
// Purpose  : Packet-granular round-robin arbiter sharing one T2MI parser among
//            several 64-bit streams, with guard gap and stall watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module t2mi_stream_arbiter #(
    parameter int NUM_STREAMS    = 4,
    parameter int DATA_WIDTH     = 64,
    parameter int SID_W          = 3,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_STREAMS-1:0]                stream_enable,
    input  logic [NUM_STREAMS-1:0]                s_valid,
    input  logic [NUM_STREAMS*DATA_WIDTH-1:0]     s_data,
    input  logic [NUM_STREAMS*(DATA_WIDTH/8)-1:0] s_byte_enable,
    input  logic [NUM_STREAMS-1:0]                s_last,
    output logic [NUM_STREAMS-1:0]                s_ready,
    output logic                                  m_data_valid,
    output logic [DATA_WIDTH-1:0]                 m_data,
    output logic [DATA_WIDTH/8-1:0]               m_byte_enable,
    output logic [SID_W-1:0]                      m_stream_id,
    output logic                                  m_sof,
    output logic                                  grant_active,
    output logic [SID_W-1:0]                      active_stream,
    output logic                                  timeout_event,
    output logic                                  abort_event,
    output logic [31:0]                           packet_count,
    output logic [15:0]                           timeout_count,
    output logic [15:0]                           abort_count
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_GRANT = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;

    localparam logic [15:0]      c_IDLE_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       c_GAP_LAST   = 4'(GAP_CYCLES - 1);
    localparam logic [SID_W-1:0] c_LAST_INIT  = SID_W'(NUM_STREAMS - 1);

    logic [1:0]       r_state;
    logic [SID_W-1:0] r_grant_id;
    logic [SID_W-1:0] r_last_grant;
    logic [15:0]      r_idle_cnt;
    logic [3:0]       r_gap_cnt;
    logic             r_first_word;

    logic [1:0]            w_state_nxt;
    logic [SID_W-1:0]      w_grant_id_nxt;
    logic [SID_W-1:0]      w_last_grant_nxt;
    logic [15:0]           w_idle_cnt_nxt;
    logic [3:0]            w_gap_cnt_nxt;
    logic                  w_first_word_nxt;
    logic                  w_m_valid_nxt;
    logic                  w_m_sof_nxt;
    logic [DATA_WIDTH-1:0] w_m_data_nxt;
    logic [NUM_BYTES-1:0]  w_m_be_nxt;
    logic [SID_W-1:0]      w_m_sid_nxt;
    logic [SID_W-1:0]      w_active_nxt;
    logic                  w_tev_nxt;
    logic                  w_aev_nxt;
    logic [31:0]           w_pkt_cnt_nxt;
    logic [15:0]           w_tmo_cnt_nxt;
    logic [15:0]           w_abt_cnt_nxt;

    logic [NUM_STREAMS-1:0] w_eligible;
    logic [NUM_STREAMS-1:0] w_hi_mask;
    logic [NUM_STREAMS-1:0] w_hi_elig;
    logic [NUM_STREAMS-1:0] w_cand;
    logic [NUM_STREAMS-1:0] w_grant_oh;
    logic [SID_W-1:0]       w_pick;
    logic [DATA_WIDTH-1:0]  w_g_data;
    logic [NUM_BYTES-1:0]   w_g_be;
    logic                   w_g_enable;
    logic                   w_g_last;
    logic                   w_xfer;

    // Round robin: prefer eligible streams above the last grant, else wrap to the lowest.
    assign w_eligible = stream_enable & s_valid;

    always_comb begin
        w_hi_mask = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            w_hi_mask[i] = (SID_W'(i) > r_last_grant);
        end
    end

    assign w_hi_elig = w_eligible & w_hi_mask;
    assign w_cand    = (|w_hi_elig) ? w_hi_elig : w_eligible;

    always_comb begin
        w_pick = '0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_pick = SID_W'(i);
            end
        end
    end

    always_comb begin
        w_grant_oh = '0;
        w_g_data   = '0;
        w_g_be     = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (r_grant_id == SID_W'(i)) begin
                w_grant_oh[i] = 1'b1;
                w_g_data      = s_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_g_be        = s_byte_enable[i*NUM_BYTES +: NUM_BYTES];
            end
        end
    end

    assign w_g_enable   = |(stream_enable & w_grant_oh);
    assign w_g_last     = |(s_last & w_grant_oh);
    assign s_ready      = (r_state == c_ST_GRANT) ? (stream_enable & w_grant_oh) : '0;
    assign w_xfer       = |(s_valid & s_ready);
    assign grant_active = (r_state == c_ST_GRANT);

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_id_nxt   = r_grant_id;
        w_last_grant_nxt = r_last_grant;
        w_idle_cnt_nxt   = r_idle_cnt;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_first_word_nxt = r_first_word;
        w_m_valid_nxt    = 1'b0;
        w_m_sof_nxt      = 1'b0;
        w_m_data_nxt     = m_data;
        w_m_be_nxt       = m_byte_enable;
        w_m_sid_nxt      = m_stream_id;
        w_active_nxt     = active_stream;
        w_tev_nxt        = 1'b0;
        w_aev_nxt        = 1'b0;
        w_pkt_cnt_nxt    = packet_count;
        w_tmo_cnt_nxt    = timeout_count;
        w_abt_cnt_nxt    = abort_count;

        case (r_state)
            c_ST_IDLE: begin
                if (|w_eligible) begin
                    w_grant_id_nxt   = w_pick;
                    w_active_nxt     = w_pick;
                    w_idle_cnt_nxt   = '0;
                    w_first_word_nxt = 1'b1;
                    w_state_nxt      = c_ST_GRANT;
                end
            end
            c_ST_GRANT: begin
                // A disabled grant holder is aborted before the watchdog is considered.
                if (!w_g_enable) begin
                    w_aev_nxt        = 1'b1;
                    w_abt_cnt_nxt    = (abort_count == 16'hFFFF) ? abort_count : abort_count + 16'd1;
                    w_last_grant_nxt = r_grant_id;
                    w_gap_cnt_nxt    = '0;
                    w_state_nxt      = c_ST_GAP;
                end else if (w_xfer) begin
                    w_m_valid_nxt    = 1'b1;
                    w_m_sof_nxt      = r_first_word;
                    w_m_data_nxt     = w_g_data;
                    w_m_be_nxt       = w_g_be;
                    w_m_sid_nxt      = r_grant_id;
                    w_first_word_nxt = 1'b0;
                    w_idle_cnt_nxt   = '0;
                    if (w_g_last) begin
                        w_pkt_cnt_nxt    = packet_count + 32'd1;
                        w_last_grant_nxt = r_grant_id;
                        w_gap_cnt_nxt    = '0;
                        w_state_nxt      = c_ST_GAP;
                    end
                end else if (r_idle_cnt == c_IDLE_LIMIT) begin
                    w_tev_nxt        = 1'b1;
                    w_tmo_cnt_nxt    = (timeout_count == 16'hFFFF) ? timeout_count : timeout_count + 16'd1;
                    w_last_grant_nxt = r_grant_id;
                    w_gap_cnt_nxt    = '0;
                    w_state_nxt      = c_ST_GAP;
                end else begin
                    w_idle_cnt_nxt = r_idle_cnt + 16'd1;
                end
            end
            c_ST_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = c_ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            r_grant_id    <= '0;
            r_last_grant  <= c_LAST_INIT;
            r_idle_cnt    <= '0;
            r_gap_cnt     <= '0;
            r_first_word  <= 1'b0;
            m_data_valid  <= 1'b0;
            m_sof         <= 1'b0;
            m_data        <= '0;
            m_byte_enable <= '0;
            m_stream_id   <= '0;
            active_stream <= '0;
            timeout_event <= 1'b0;
            abort_event   <= 1'b0;
            packet_count  <= '0;
            timeout_count <= '0;
            abort_count   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_last_grant  <= w_last_grant_nxt;
            r_idle_cnt    <= w_idle_cnt_nxt;
            r_gap_cnt     <= w_gap_cnt_nxt;
            r_first_word  <= w_first_word_nxt;
            m_data_valid  <= w_m_valid_nxt;
            m_sof         <= w_m_sof_nxt;
            m_data        <= w_m_data_nxt;
            m_byte_enable <= w_m_be_nxt;
            m_stream_id   <= w_m_sid_nxt;
            active_stream <= w_active_nxt;
            timeout_event <= w_tev_nxt;
            abort_event   <= w_aev_nxt;
            packet_count  <= w_pkt_cnt_nxt;
            timeout_count <= w_tmo_cnt_nxt;
            abort_count   <= w_abt_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_t2mi_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_t2mi_stream_arbiter
// Purpose  : Directed bench for t2mi_stream_arbiter with a per-cycle reference
//            model and hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_t2mi_stream_arbiter;
    localparam int NS  = 4;
    localparam int DW  = 64;
    localparam int NB  = 8;
    localparam int GAP = 2;
    localparam int TMO = 16;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  be;
        logic        last;
    } word_t;

    logic             clk;
    logic             rst_n;
    logic [NS-1:0]    stream_enable;
    logic [NS-1:0]    s_valid;
    logic [NS*DW-1:0] s_data;
    logic [NS*NB-1:0] s_byte_enable;
    logic [NS-1:0]    s_last;
    logic [NS-1:0]    s_ready;
    logic             m_data_valid;
    logic [DW-1:0]    m_data;
    logic [NB-1:0]    m_byte_enable;
    logic [2:0]       m_stream_id;
    logic             m_sof;
    logic             grant_active;
    logic [2:0]       active_stream;
    logic             timeout_event;
    logic             abort_event;
    logic [31:0]      packet_count;
    logic [15:0]      timeout_count;
    logic [15:0]      abort_count;

    t2mi_stream_arbiter #(
        .NUM_STREAMS   (NS),
        .DATA_WIDTH    (DW),
        .SID_W         (3),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stream_enable(stream_enable),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_byte_enable(s_byte_enable),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .m_data_valid (m_data_valid),
        .m_data       (m_data),
        .m_byte_enable(m_byte_enable),
        .m_stream_id  (m_stream_id),
        .m_sof        (m_sof),
        .grant_active (grant_active),
        .active_stream(active_stream),
        .timeout_event(timeout_event),
        .abort_event  (abort_event),
        .packet_count (packet_count),
        .timeout_count(timeout_count),
        .abort_count  (abort_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    word_t srcq [NS][$];
    logic [NS-1:0] acc;

    // Reference model: who owns the parser, how long the gap still lasts, how long the owner has been quiet.
    int          owner;
    int          prev;
    int          gap_left;
    int          quiet;
    bit          fresh;
    logic        e_valid, e_sof, e_tev, e_aev;
    logic [63:0] e_data;
    logic [7:0]  e_be;
    logic [2:0]  e_sid, e_active;
    logic [31:0] e_pkts;
    logic [15:0] e_touts, e_aborts;

    logic [NS-1:0]    c_en, c_v, c_last;
    logic [NS*DW-1:0] c_data;
    logic [NS*NB-1:0] c_be;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic bit_at(logic [NS-1:0] v, int i);
        logic [NS-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic word_t mk(logic [63:0] d, logic [7:0] be, logic last);
        word_t w;
        w.d = d; w.be = be; w.last = last;
        return w;
    endfunction

    task automatic model_reset();
        owner = -1; prev = NS - 1; gap_left = 0; quiet = 0; fresh = 1'b0;
        e_valid = 1'b0; e_sof = 1'b0; e_tev = 1'b0; e_aev = 1'b0;
        e_data = '0; e_be = '0; e_sid = '0; e_active = '0;
        e_pkts = '0; e_touts = '0; e_aborts = '0;
    endtask

    task automatic release_owner();
        prev = owner;
        owner = -1;
        gap_left = GAP;
    endtask

    task automatic model_step();
        int c;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e_valid = 1'b0; e_sof = 1'b0; e_tev = 1'b0; e_aev = 1'b0;
        if (owner >= 0) begin
            if (!bit_at(c_en, owner)) begin
                e_aev = 1'b1;
                if (e_aborts != 16'hFFFF) e_aborts = e_aborts + 16'd1;
                release_owner();
            end else if (bit_at(c_v, owner)) begin
                e_valid = 1'b1;
                e_sof   = fresh;
                e_data  = 64'(c_data >> (owner * DW));
                e_be    = 8'(c_be >> (owner * NB));
                e_sid   = 3'(owner);
                fresh   = 1'b0;
                quiet   = 0;
                if (bit_at(c_last, owner)) begin
                    e_pkts = e_pkts + 32'd1;
                    release_owner();
                end
            end else begin
                quiet++;
                if (quiet >= TMO) begin
                    e_tev = 1'b1;
                    if (e_touts != 16'hFFFF) e_touts = e_touts + 16'd1;
                    release_owner();
                end
            end
        end else if (gap_left > 0) begin
            gap_left--;
        end else begin
            for (int k = 1; k <= NS; k++) begin
                c = (prev + k) % NS;
                if (owner < 0 && bit_at(c_en, c) && bit_at(c_v, c)) begin
                    owner    = c;
                    e_active = 3'(c);
                    fresh    = 1'b1;
                    quiet    = 0;
                end
            end
        end
    endtask

    task automatic compare_model();
        logic [NS-1:0] exp_ready;
        exp_ready = '0;
        if (owner >= 0 && bit_at(stream_enable, owner)) exp_ready = NS'(1) << owner;
        check("s_ready",       64'(s_ready),       64'(exp_ready));
        check("grant_active",  64'(grant_active),  64'(owner >= 0));
        check("m_data_valid",  64'(m_data_valid),  64'(e_valid));
        check("m_sof",         64'(m_sof),         64'(e_sof));
        check("m_data",        m_data,             e_data);
        check("m_byte_enable", 64'(m_byte_enable), 64'(e_be));
        check("m_stream_id",   64'(m_stream_id),   64'(e_sid));
        check("active_stream", 64'(active_stream), 64'(e_active));
        check("timeout_event", 64'(timeout_event), 64'(e_tev));
        check("abort_event",   64'(abort_event),   64'(e_aev));
        check("packet_count",  64'(packet_count),  64'(e_pkts));
        check("timeout_count", 64'(timeout_count), 64'(e_touts));
        check("abort_count",   64'(abort_count),   64'(e_aborts));
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            if (srcq[i].size() > 0) begin
                s_valid[i]                = 1'b1;
                s_data[i*DW +: DW]        = srcq[i][0].d;
                s_byte_enable[i*NB +: NB] = srcq[i][0].be;
                s_last[i]                 = srcq[i][0].last;
            end else begin
                s_valid[i]                = 1'b0;
                s_data[i*DW +: DW]        = '0;
                s_byte_enable[i*NB +: NB] = '0;
                s_last[i]                 = 1'b0;
            end
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge, then update sources.
    task automatic tick();
        @(negedge clk);
        c_en = stream_enable; c_v = s_valid; c_last = s_last;
        c_data = s_data; c_be = s_byte_enable;
        acc = rst_n ? (s_valid & s_ready) : '0;
        if (rst_n) compare_model();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        for (int i = 0; i < NS; i++) begin
            if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        end
        drive();
    endtask

    function automatic int q_at(int q[$], int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    int sofs[$];
    int t_sof2, t_tev, n_tev, n_abt, n_s1;
    bit saw_r1, done;

    initial begin
        model_reset();
        rst_n = 1'b0;
        stream_enable = '0;
        s_valid = '0; s_data = '0; s_byte_enable = '0; s_last = '0;
        drive();
        tick(); tick();

        check("reset m_data_valid", 64'(m_data_valid), 64'd0);
        check("reset packet_count", 64'(packet_count), 64'd0);
        check("reset grant_active", 64'(grant_active), 64'd0);
        check("reset s_ready",      64'(s_ready),      64'd0);

        // Single stream 0 packet, three words, last has an all-zero byte enable.
        rst_n = 1'b1;
        stream_enable = '1;
        srcq[0].push_back(mk(64'h4700_1122_3344_5566, 8'hFF, 1'b0));
        srcq[0].push_back(mk(64'h1111_2222_3333_4444, 8'h0F, 1'b0));
        srcq[0].push_back(mk(64'h2222_AAAA_BBBB_CCCC, 8'h00, 1'b1));
        drive();
        tick(); tick();
        check("t1 word0 valid", 64'(m_data_valid), 64'd1);
        check("t1 word0 data",  m_data,            64'h4700_1122_3344_5566);
        check("t1 word0 sof",   64'(m_sof),        64'd1);
        tick();
        check("t1 word1 sof",   64'(m_sof),        64'd0);
        tick();
        check("t1 word2 data",  m_data,             64'h2222_AAAA_BBBB_CCCC);
        check("t1 word2 be",    64'(m_byte_enable), 64'd0);
        check("t1 packets",     64'(packet_count),  64'd1);
        tick();
        check("t1 gap valid",   64'(m_data_valid), 64'd0);
        check("t1 gap grant",   64'(grant_active), 64'd0);
        repeat (4) tick();

        // Two competing streams, two 2-word packets each; last grant was stream 0.
        for (int p = 0; p < 2; p++) begin
            srcq[0].push_back(mk(64'hA000 + 64'(2*p), 8'hFF, 1'b0));
            srcq[0].push_back(mk(64'hA001 + 64'(2*p), 8'hFF, 1'b1));
            srcq[1].push_back(mk(64'hB000 + 64'(2*p), 8'hFF, 1'b0));
            srcq[1].push_back(mk(64'hB001 + 64'(2*p), 8'hFF, 1'b1));
        end
        drive();
        sofs.delete();
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            tick();
            if (m_sof) sofs.push_back(int'(m_stream_id));
            if (packet_count == 32'd5) done = 1'b1;
        end
        check("t2 finished", 64'(done), 64'd1);
        check("t2 grant0", 64'(q_at(sofs, 0)), 64'd1);
        check("t2 grant1", 64'(q_at(sofs, 1)), 64'd0);
        check("t2 grant2", 64'(q_at(sofs, 2)), 64'd1);
        check("t2 grant3", 64'(q_at(sofs, 3)), 64'd0);
        repeat (4) tick();

        // Stream 2 sends one word then goes silent; stream 3 waits behind it.
        srcq[2].push_back(mk(64'hC000_0000_0000_0001, 8'h3C, 1'b0));
        srcq[3].push_back(mk(64'hD000_0000_0000_0001, 8'hFF, 1'b1));
        drive();
        sofs.delete();
        done = 1'b0; n_tev = 0; t_sof2 = 0; t_tev = 0;
        for (int n = 0; n < 80 && !done; n++) begin
            tick();
            if (m_sof) sofs.push_back(int'(m_stream_id));
            if (m_sof && m_stream_id == 3'd2) t_sof2 = cyc;
            if (timeout_event) begin n_tev++; t_tev = cyc; end
            if (packet_count == 32'd6) done = 1'b1;
        end
        check("t3 finished",      64'(done),            64'd1);
        check("t3 timeout pulses", 64'(n_tev),          64'd1);
        check("t3 timeout delay", 64'(t_tev - t_sof2),  64'd16);
        check("t3 timeout_count", 64'(timeout_count),   64'd1);
        check("t3 next grant",    64'(q_at(sofs, 1)),   64'd3);
        repeat (4) tick();

        // Stream 1 is disabled after its first word of a 4-word packet.
        for (int w = 0; w < 4; w++) srcq[1].push_back(mk(64'hE000 + 64'(w), 8'hFF, w == 3));
        drive();
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            tick();
            if (m_sof) done = 1'b1;
        end
        check("t4 first word", 64'(done), 64'd1);
        stream_enable[1] = 1'b0;
        #1;
        check("t4 ready drop", 64'(s_ready[1]), 64'd0);
        n_abt = 0; n_s1 = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (abort_event) n_abt++;
            if (m_data_valid && m_stream_id == 3'd1) n_s1++;
        end
        check("t4 abort pulses", 64'(n_abt),       64'd1);
        check("t4 abort_count",  64'(abort_count), 64'd1);
        check("t4 extra words",  64'(n_s1),        64'd0);

        // Stream 1 stays disabled while still holding valid words.
        srcq[0].push_back(mk(64'hF000, 8'hFF, 1'b0));
        srcq[0].push_back(mk(64'hF001, 8'hFF, 1'b1));
        drive();
        sofs.delete();
        saw_r1 = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (m_sof) sofs.push_back(int'(m_stream_id));
            if (s_ready[1]) saw_r1 = 1'b1;
        end
        check("t5 grants",       64'(sofs.size()),  64'd1);
        check("t5 grant id",     64'(q_at(sofs, 0)), 64'd0);
        check("t5 ready1 seen",  64'(saw_r1),        64'd0);
        check("t5 packets",      64'(packet_count),  64'd7);

        // Reset asserted in the middle of a stream 0 packet.
        for (int w = 0; w < 4; w++) srcq[0].push_back(mk(64'h6000 + 64'(w), 8'hFF, w == 3));
        drive();
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            tick();
            if (m_data_valid) done = 1'b1;
        end
        check("t6 mid packet", 64'(done), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6 rst m_data_valid",  64'(m_data_valid),  64'd0);
        check("t6 rst m_data",        m_data,             64'd0);
        check("t6 rst m_stream_id",   64'(m_stream_id),   64'd0);
        check("t6 rst grant_active",  64'(grant_active),  64'd0);
        check("t6 rst s_ready",       64'(s_ready),       64'd0);
        check("t6 rst active_stream", 64'(active_stream), 64'd0);
        check("t6 rst packet_count",  64'(packet_count),  64'd0);
        check("t6 rst abort_count",   64'(abort_count),   64'd0);
        check("t6 rst timeout_count", 64'(timeout_count), 64'd0);
        for (int i = 0; i < NS; i++) srcq[i].delete();
        stream_enable = '1;
        drive();
        tick(); tick();
        rst_n = 1'b1;
        srcq[1].push_back(mk(64'h7100, 8'hFF, 1'b1));
        srcq[0].push_back(mk(64'h7000, 8'hFF, 1'b1));
        drive();
        sofs.delete();
        done = 1'b0;
        for (int n = 0; n < 30 && !done; n++) begin
            tick();
            if (m_sof) sofs.push_back(int'(m_stream_id));
            if (packet_count == 32'd2) done = 1'b1;
        end
        check("t6 finished",      64'(done),           64'd1);
        check("t6 first grant",   64'(q_at(sofs, 0)),  64'd0);
        check("t6 second grant",  64'(q_at(sofs, 1)),  64'd1);
        check("t6 abort_count",   64'(abort_count),    64'd0);
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/t2mi_stream_arbiter.md
# t2mi_stream_arbiter

Packet-granular round-robin arbiter that shares one `parallel_t2mi_parser` among up to NUM_STREAMS 64-bit T2MI input streams. It grants one stream at a time and holds the grant until that stream's end-of-packet word. After each grant it inserts a guard gap so the parser can return to sync search. A watchdog releases stalled streams, and status counters report packets, timeouts and aborts.

## Interface
- NUM_STREAMS, 4, number of requesters (2..8)
- DATA_WIDTH, 64, word width; NUM_BYTES = DATA_WIDTH/8
- SID_W, 3, stream-id width (≥ clog2(NUM_STREAMS))
- GAP_CYCLES, 2, idle cycles between grants (1..15)
- TIMEOUT_CYCLES, 1024, consecutive no-transfer cycles before forced release (2..65535)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stream_enable  in  NUM_STREAMS  per-stream enable (config)
- s_valid  in  NUM_STREAMS  word available per stream
- s_data  in  NUM_STREAMS*DATA_WIDTH  stream i at [i*DATA_WIDTH +: DATA_WIDTH]
- s_byte_enable  in  NUM_STREAMS*NUM_BYTES  stream i at [i*NUM_BYTES +: NUM_BYTES]
- s_last  in  NUM_STREAMS  word is last of packet
- s_ready  out  NUM_STREAMS  word accepted when s_valid&s_ready
- m_data_valid  out  1  to parser data_valid
- m_data  out  DATA_WIDTH  to parser data_in
- m_byte_enable  out  NUM_BYTES  to parser byte_enable
- m_stream_id  out  SID_W  source of current m_data
- m_sof  out  1  first word of a grant
- grant_active  out  1  state == GRANT
- active_stream  out  SID_W  currently/last granted stream
- timeout_event, abort_event  out  1  one-cycle pulses
- packet_count  out  32  packets forwarded (wraps)
- timeout_count, abort_count  out  16  saturating at 16'hFFFF

## Operation
- States: IDLE, GRANT, GAP.
- Eligible stream i: `stream_enable[i] & s_valid[i]`.
- IDLE: if any stream is eligible, pick the first eligible stream scanning from last_grant+1 upward with wrap. Then set grant_id and active_stream, clear idle_cnt, set first_word, and go to GRANT. last_grant resets to NUM_STREAMS-1, so stream 0 wins first.
- GRANT: s_ready[grant_id] = `stream_enable[grant_id]` (combinational from state regs and enable). All other s_ready bits are 0. s_ready is 0 in IDLE and GAP.
- Transfer = `s_valid[g] & s_ready[g]`. On each transfer:
  - register data and byte_enable into m_*, m_stream_id=g, m_data_valid=1, m_sof=first_word.
  - clear first_word and idle_cnt.
- Transfer with s_last[g]: packet_count+1, last_grant←g, go to GAP.
- No transfer while enabled: idle_cnt+1. When idle_cnt reaches TIMEOUT_CYCLES-1 with no transfer that cycle, pulse timeout_event, increment timeout_count (saturating), set last_grant←g, go to GAP.
- stream_enable[g] low in GRANT: s_ready drops the same cycle. Next edge pulses abort_event, increments abort_count (saturating), sets last_grant←g, goes to GAP.
- GAP: gap_cnt counts GAP_CYCLES cycles, then IDLE. No s_ready and no output during GAP.
- Simultaneous events: transfer beats timeout. A transfer with s_last beats neither since it ends the grant normally. Abort is checked before timeout.
- m_data_valid, m_sof and the event pulses are 1 only in the cycle after their cause. m_data, m_byte_enable and m_stream_id hold their last value otherwise.
- byte_enable is passed through unchanged, including all-zero words.

## Timing
- Reset values: all outputs 0. State IDLE, last_grant = NUM_STREAMS-1, all internal counters 0.
- Request seen in IDLE at edge N: GRANT from N+1, s_ready high in cycle N+1, output valid after edge N+2.
- Data latency: 1 cycle from accepted transfer to m_data_valid.
- Throughput in GRANT: 1 word/cycle. No m-side backpressure.
- Minimum grant-to-grant spacing after a last word: GAP_CYCLES cycles in GAP plus 1 cycle in IDLE.
- Mid-operation reset forces IDLE immediately and clears outputs asynchronously. No partial output word is emitted afterwards.

## Test plan
- Single stream 0: 3 words 0x47.., 0x11.., 0x22.. with last on word 3 → m_data_valid cycles 3, 4, 5; m_sof only with 0x47 word; packet_count=1; GAP 2 cycles.
- Streams 0 and 1 both continuously requesting 2-word packets → grants alternate 0,1,0,1; m_stream_id follows; packet_count=4 after 4 packets.
- Stream 2 granted, then s_valid low, TIMEOUT_CYCLES=16 → release after 16 idle cycles; timeout_event one pulse; timeout_count=1; stream 3 is granted next.
- stream_enable[1] cleared after 1 word of a 4-word packet → s_ready[1] low the same cycle; abort_count=1; no further stream-1 words output.
- Stream 1 disabled, streams 0 and 1 valid → only stream 0 granted; s_ready[1] never 1.
- rst_n asserted mid-packet → all outputs 0 asynchronously. After release, stream 0 gets the first grant again and counters restart at 0.
